rf_access_ctrl: RTL
===================

# rf_access_ctrl

Burst access controller that initiates reads and writes into the register file. A host presents a burst request: start address, length, direction. For writes, the host also streams data words. The controller drives the register file's address, write-data and write-enable pins with the file's exact pipeline timing. It returns read data as a response stream. It sits between the datapath sequencer and the register file.

## Interface
Parameters:
- DATA_WIDTH, 16, word width; matches register-file data width
- ADDR_WIDTH, 4, register-file address width; depth = 2**ADDR_WIDTH

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  burst request present
- req_ready  out  1  controller accepts request (high only in IDLE)
- req_write  in  1  1 = write burst, 0 = read burst
- req_addr  in  ADDR_WIDTH  first address
- req_len  in  ADDR_WIDTH  beats minus one (1..2**ADDR_WIDTH beats)
- wdata_valid  in  1  write word present
- wdata_ready  out  1  write word consumed this cycle
- wdata  in  DATA_WIDTH  write word
- rsp_valid  out  1  one-cycle pulse per read beat
- rsp_rdata  out  DATA_WIDTH  read word, valid with rsp_valid
- done  out  1  one-cycle pulse when burst fully retired
- rf_address  out  ADDR_WIDTH  to register-file address
- rf_wdata  out  DATA_WIDTH  to register-file write data
- rf_mode  out  1  to register-file write enable
- rf_rdata  in  DATA_WIDTH  from register-file read data

## Operation
- Register-file contract:
  - The file registers address and data on every clk edge.
  - It commits a write on an edge where mode=1, using the address/data registered at the previous edge.
  - Read data is combinational from the registered address.
- States: IDLE, ISSUE, FLUSH.
- IDLE:
  - req_ready=1.
  - On req_valid, latch direction, addr, and beat counter (req_len), then go to ISSUE.
- ISSUE: at most one beat issued per cycle.
  - Read: a beat issues every cycle.
  - Write: a beat issues only when wdata_valid=1. wdata_ready = write burst && ISSUE, combinationally.
  - On issue, register rf_address=addr and rf_wdata=wdata (write), then addr+1 and counter-1.
  - After the last beat, go to FLUSH.
- Write-enable tracking: rf_mode is a registered copy of "write beat issued last cycle". Stall cycles therefore produce rf_mode=0 bubbles aligned with the file pipeline.
- Read return:
  - Capture rf_rdata one cycle after a read beat's address is driven.
  - Present it as rsp_rdata with rsp_valid one cycle later.
  - No response backpressure.
- FLUSH:
  - Wait for the in-flight pipeline to drain: 1 cycle for writes, 2 for reads.
  - Pulse done, return to IDLE.
- Address arithmetic: modulo 2**ADDR_WIDTH; wraps past the top without error.
- rf_address and rf_wdata hold their last value when no beat issues. Only rf_mode qualifies writes.

## Timing
- Reset values (async, immediate):
  - state=IDLE
  - req_ready=1, wdata_ready=0, rsp_valid=0, done=0, rf_mode=0
  - rf_address=0, rf_wdata=0, rsp_rdata=0
- Accept edge = cycle 0.
- Beat k issued in cycle t_k (t_0 ≥ 1) drives rf_address in cycle t_k+1.
- Write beat k: rf_mode=1 in cycle t_k+2; the file commits at the end of that cycle.
- Read beat k: rsp_valid in cycle t_k+3. For an unstalled burst, responses are back-to-back.
- N-beat unstalled burst, done cycle:
  - Write: done at cycle N+3.
  - Read: done at cycle N+4.
  - req_ready returns the cycle after done.
- A request presented while busy waits; req_ready=0 in ISSUE and FLUSH.
- wdata_valid outside a write ISSUE is ignored (wdata_ready=0).
- Reset mid-burst: rf_mode drops immediately, and no partial response or done is emitted. A write whose rf_mode edge coincides with reset assertion is not guaranteed.

## Test plan
- Single write then read: write 0xA5A5 @3, len 0 -> rf_mode high exactly one cycle with rf_address=3. Read @3 -> rsp_rdata=0xA5A5, done 4 and 5 cycles after accept respectively.
- Full-depth write burst: @0 len 15, data 0x0100+k, wdata_valid constant -> rf_mode high 16 consecutive cycles. Read burst returns 16 back-to-back rsp_valid with 0x0100..0x010F.
- Wrap-around: write @14 len 3 -> addresses 14,15,0,1. Read @14 len 3 returns the same words in order.
- Write stall: toggle wdata_valid 1,0,0,1,1 for a 3-beat burst -> rf_mode pattern 1,0,0,1,1 (shifted two cycles), no duplicate or lost beats, single done.
- Back-to-back requests: req_valid held high with a second request -> second accepted only the cycle after done. No overlap on rf_address.
- Reset mid-burst: assert rst during a read burst beat 2 of 8 -> all outputs at reset values the same cycle. After release, req_ready=1 and no stray rsp_valid/done.

Source files
------------

// File: rtl/rf_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rf_access_ctrl
//  Purpose  : Burst read/write controller for a registered-address register
//             file. Drives address/data/write-enable with the file's pipeline
//             timing and returns read words as a response stream.
//  Revision : 1.0  initial release
// ============================================================================
module rf_access_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [ADDR_WIDTH-1:0] req_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rf_address,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  rf_mode,
  input  logic [DATA_WIDTH-1:0] rf_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]            flush_q, flush_d;
  logic [ADDR_WIDTH-1:0] rf_address_q, rf_address_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  // wr_iss/rd_iss: a beat of that kind issued in the previous cycle
  logic                  wr_iss_q, wr_iss_d;
  logic                  rd_iss_q, rd_iss_d;
  // rd_p2: the file's read data for that beat is on rf_rdata this cycle
  logic                  rd_p2_q, rd_p2_d;
  logic                  rf_mode_q, rf_mode_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  beat;

  // Next-state, beat issue and pipeline tracking
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    flush_d      = flush_q;
    rf_address_d = rf_address_q;
    rf_wdata_d   = rf_wdata_q;
    wr_iss_d     = 1'b0;
    rd_iss_d     = 1'b0;
    beat         = 1'b0;
    done         = 1'b0;
    req_ready    = (state_q == S_IDLE);
    wdata_ready  = (state_q == S_ISSUE) && write_q;
    // Write enable lines up with the file committing the address/data it
    // registered one edge after the beat was driven.
    rf_mode_d    = wr_iss_q;
    rd_p2_d      = rd_iss_q;
    rsp_valid_d  = rd_p2_q;
    rsp_rdata_d  = rd_p2_q ? rf_rdata : rsp_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          cnt_d   = req_len;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        beat = !write_q || wdata_valid;
        if (beat) begin
          rf_address_d = addr_q;
          if (write_q) begin
            rf_wdata_d = wdata;
          end
          wr_iss_d = write_q;
          rd_iss_d = !write_q;
          addr_d   = addr_q + 1'b1;
          cnt_d    = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = S_FLUSH;
            // Reads need one extra cycle for the response register.
            flush_d = write_q ? 2'd2 : 2'd3;
          end
        end
      end
      S_FLUSH: begin
        if (flush_q == 2'd0) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else begin
          flush_d = flush_q - 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and pipeline registers; reset clears every output immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      write_q      <= 1'b0;
      addr_q       <= '0;
      cnt_q        <= '0;
      flush_q      <= 2'd0;
      rf_address_q <= '0;
      rf_wdata_q   <= '0;
      wr_iss_q     <= 1'b0;
      rd_iss_q     <= 1'b0;
      rd_p2_q      <= 1'b0;
      rf_mode_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      flush_q      <= flush_d;
      rf_address_q <= rf_address_d;
      rf_wdata_q   <= rf_wdata_d;
      wr_iss_q     <= wr_iss_d;
      rd_iss_q     <= rd_iss_d;
      rd_p2_q      <= rd_p2_d;
      rf_mode_q    <= rf_mode_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  assign rf_address = rf_address_q;
  assign rf_wdata   = rf_wdata_q;
  assign rf_mode    = rf_mode_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;

endmodule
`default_nettype wire
